// File: rtl/ask_pkg.sv
// Shared definitions for the ASK demodulator: sample widths, parameter defaults and FSM states.
package ask_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned MAG_W    = SAMPLE_W - 1;

  localparam int unsigned DEF_SAMPLES_PER_BIT = 512;
  localparam int unsigned DEF_THRESH_MAG      = 8192;
  localparam int unsigned DEF_LOSS_BITS       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHunt,
    StTrack
  } ask_state_e;

endpackage

// File: rtl/ask_abs_sat.sv
// Absolute value of a signed carrier sample; the most negative code saturates to the largest
// positive magnitude so the result always fits in SAMPLE_W-1 bits.
module ask_abs_sat
  import ask_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic        [MAG_W-1:0]    mag_o
);

  logic [SAMPLE_W-1:0] neg;
  logic                is_min;

  always_comb begin
    neg    = -sample_i;
    is_min = sample_i[SAMPLE_W-1] && (sample_i[SAMPLE_W-2:0] == '0);
    if (is_min) begin
      mag_o = '1;
    end else if (sample_i[SAMPLE_W-1]) begin
      mag_o = neg[MAG_W-1:0];
    end else begin
      mag_o = sample_i[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/ask_demodulation.sv
// On-off keyed carrier demodulator: integrates sample magnitude over each bit period, slices
// against a fixed threshold and tracks lock until LOSS_BITS consecutive zeros are seen.
module ask_demodulation
  import ask_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
  parameter int unsigned THRESH_MAG      = DEF_THRESH_MAG,
  parameter int unsigned LOSS_BITS       = DEF_LOSS_BITS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       locked
);

  localparam int unsigned CntW  = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned AccW  = MAG_W + CntW;
  localparam int unsigned LossW = $clog2(LOSS_BITS + 1);

  localparam logic [63:0]      Thresh  = 64'(THRESH_MAG) * 64'(SAMPLES_PER_BIT);
  localparam logic [CntW-1:0]  LastIdx = CntW'(SAMPLES_PER_BIT - 1);
  localparam logic [LossW-1:0] LossMax = LossW'(LOSS_BITS);

  ask_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [AccW-1:0]  acc_q;
  logic [LossW-1:0] loss_q;
  logic             dout_q;
  logic             dout_valid_q;
  logic             locked_q;

  logic [MAG_W-1:0] mag;
  logic [AccW-1:0]  sum;
  logic             bit_one;
  logic             mag_hit;

  ask_abs_sat u_abs_sat (
    .sample_i (din),
    .mag_o    (mag)
  );

  // acc_q never exceeds (SAMPLES_PER_BIT-1) full-scale samples, so the sum cannot wrap.
  assign sum     = acc_q + AccW'(mag);
  assign bit_one = 64'(sum) >= Thresh;
  assign mag_hit = 32'(mag) >= THRESH_MAG;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_q        <= '0;
      loss_q       <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (!enable) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        acc_q    <= '0;
        loss_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q  <= StHunt;
            cnt_q    <= '0;
            acc_q    <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
          end
          StHunt: begin
            // The first strong sample is index 0 of the new bit.
            if (mag_hit) begin
              acc_q    <= AccW'(mag);
              cnt_q    <= CntW'(1);
              state_q  <= StTrack;
              locked_q <= 1'b1;
            end
          end
          StTrack: begin
            if (cnt_q == LastIdx) begin
              dout_q       <= bit_one;
              dout_valid_q <= 1'b1;
              acc_q        <= '0;
              cnt_q        <= '0;
              if (bit_one) begin
                loss_q <= '0;
              end else if (loss_q + LossW'(1) == LossMax) begin
                loss_q   <= '0;
                state_q  <= StHunt;
                locked_q <= 1'b0;
              end else begin
                loss_q <= loss_q + LossW'(1);
              end
            end else begin
              acc_q <= sum;
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_ask_demodulation.sv
// Directed bench for ask_demodulation (16 samples/bit, threshold 8192, loss after 8 zeros).
// Expected bits and strobe cycles are queued by the stimulus and checked by a separate monitor.
module tb_ask_demodulation;

  localparam int unsigned Spb = 16;

  logic               clk;
  logic               reset_n;
  logic               enable;
  logic signed [15:0] din;
  logic               dout;
  logic               dout_valid;
  logic               locked;

  typedef struct {
    logic d;
    int   at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  ask_demodulation #(
    .SAMPLES_PER_BIT (Spb),
    .THRESH_MAG      (8192),
    .LOSS_BITS       (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue in value and cycle.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got dout_valid=1 dout=%0b at cycle %0d, want none",
                 dout, cyc);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.d || cyc != e.at_cyc) begin
          n_err++;
          $display("FAIL strobe: got dout=%0b at cycle %0d, want dout=%0b at cycle %0d",
                   dout, cyc, e.d, e.at_cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      din = v;
      tick();
    end
  endtask

  // One full bit: sample 0 = s0, later samples alternate even/odd by index.
  task automatic send_bit(input logic signed [15:0] s0, input logic signed [15:0] ev,
                          input logic signed [15:0] od, input logic exp_d);
    exp_t e;
    for (int i = 0; i < Spb; i++) begin
      din = (i == 0) ? s0 : ((i % 2 == 0) ? ev : od);
      if (i == Spb - 1) begin
        e.d      = exp_d;
        e.at_cyc = cyc + 1;
        exp_q.push_back(e);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    enable  = 1'b1;
    din     = '0;
    tick();

    // Reset held with a toggling carrier: outputs stay quiet.
    for (int i = 0; i < 10; i++) begin
      din = (i % 2 == 0) ? 16'sd20000 : -16'sd20000;
      tick();
      check("reset_outputs", int'({dout, dout_valid, locked}), 0);
    end
    reset_n = 1'b1;

    // No carrier: never locks.
    hold(16'sd0, 200);
    check("no_carrier_locked", int'(locked), 0);

    // Acquire: alternating +/-20000 gives 320000 >= 131072, then silence gives 0.
    send_bit(16'sd20000, 16'sd20000, -16'sd20000, 1'b1);
    check("acquire_locked", int'(locked), 1);
    send_bit(16'sd0, 16'sd0, 16'sd0, 1'b0);

    // Saturated full-scale negative: 16*32767 = 524272 per bit, fits 19 bits.
    for (int b = 0; b < 3; b++) send_bit(-16'sd32768, -16'sd32768, -16'sd32768, 1'b1);

    // Threshold boundary: exactly 131072 is a one, 131071 is a zero.
    send_bit(16'sd8192, 16'sd8192, -16'sd8192, 1'b1);
    send_bit(16'sd8191, 16'sd8192, 16'sd8192, 1'b0);
    send_bit(16'sd8192, 16'sd8192, 16'sd8192, 1'b1);

    // Carrier loss: locked survives 7 zeros and drops on the 8th decision.
    for (int b = 0; b < 7; b++) send_bit(16'sd0, 16'sd0, 16'sd0, 1'b0);
    check("loss_7_locked", int'(locked), 1);
    send_bit(16'sd0, 16'sd0, 16'sd0, 1'b0);
    check("loss_8_locked", int'(locked), 0);
    hold(16'sd0, 20);
    check("hunt_after_loss", int'(locked), 0);

    // Re-acquire, then drop enable at sample index 5 of the next bit.
    send_bit(16'sd20000, 16'sd20000, -16'sd20000, 1'b1);
    hold(16'sd20000, 5);
    enable = 1'b0;
    din    = 16'sd20000;
    tick();
    check("disable_locked", int'(locked), 0);
    check("disable_valid", int'(dout_valid), 0);
    check("disable_dout_hold", int'(dout), 1);
    hold(16'sd20000, 5);
    enable = 1'b1;
    hold(16'sd0, 20);
    check("reenable_no_lock", int'(locked), 0);
    send_bit(16'sd20000, 16'sd20000, -16'sd20000, 1'b1);
    check("reenable_locked", int'(locked), 1);

    // Asynchronous reset mid-bit: abandoned bit, outputs cleared immediately.
    hold(16'sd20000, 7);
    reset_n = 1'b0;
    #1;
    check("async_reset_dout", int'(dout), 0);
    check("async_reset_locked", int'(locked), 0);
    hold(16'sd20000, 3);
    reset_n = 1'b1;
    hold(16'sd0, 2);
    check("post_reset_no_lock", int'(locked), 0);
    send_bit(-16'sd20000, -16'sd20000, 16'sd20000, 1'b1);
    send_bit(16'sd0, 16'sd0, 16'sd0, 1'b0);
    hold(16'sd0, 4);
    check("final_dout", int'(dout), 0);
    check("pending_expectations", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ask_demodulation.md
ASK_DEMODULATION -- requirements
Module: ask_demodulation

Interface
REQ-001 The module SHALL have parameter SAMPLES_PER_BIT, default 512, meaning carrier samples per data bit (power of two, 4..4096).
REQ-002 The module SHALL have parameter THRESH_MAG, default 8192, meaning the mean per-sample magnitude that decides a "1".
REQ-003 The module SHALL have parameter LOSS_BITS, default 8, meaning the consecutive "0" decisions that declare carrier loss.
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: enable  input  1  high = demodulator active; low = forced to IDLE.
REQ-007 Port: din  input  16  modulated carrier sample, two's-complement signed, one per clock.
REQ-008 Port: dout  output  1  recovered data bit, registered, valid when dout_valid=1.
REQ-009 Port: dout_valid  output  1  one-cycle strobe per recovered bit.
REQ-010 Port: locked  output  1  high while in TRACK.

Function
REQ-011 Magnitude SHALL be |din|, with -32768 saturated to 32767 (15-bit unsigned result).
REQ-012 Accumulator SHALL be 15+log2(SAMPLES_PER_BIT) bits wide and SHALL never wrap.
REQ-013 Decision threshold SHALL be THRESH_MAG*SAMPLES_PER_BIT, compared as accumulated sum >= threshold.
REQ-014 FSM states SHALL be IDLE, HUNT, TRACK.
REQ-015 IDLE: with enable=1, next state HUNT; counter, accumulator and loss counter held at 0.
REQ-016 HUNT: first sample with magnitude >= THRESH_MAG SHALL be sample index 0 of bit 0; it is accumulated and the state moves to TRACK on that edge.
REQ-017 TRACK: each edge accumulates magnitude and increments the sample counter modulo SAMPLES_PER_BIT.
REQ-018 On the edge capturing sample index SAMPLES_PER_BIT-1, dout SHALL take the decision over (accumulator + current magnitude), dout_valid SHALL be 1 for exactly the following cycle, and the accumulator SHALL clear.
REQ-019 Latency: dout_valid SHALL assert in the cycle after the last sample of a bit, with no gaps between consecutive bits (one strobe every SAMPLES_PER_BIT cycles).
REQ-020 Loss counter SHALL increment on each "0" decision and clear on each "1"; when it reaches LOSS_BITS the FSM SHALL return to HUNT on that same edge. That bit is still reported.
REQ-021 enable=0 in any state SHALL force IDLE on the next edge: accumulator, counter and loss counter cleared; dout_valid=0; dout holds its last value; a partial bit is discarded.
REQ-022 locked SHALL be registered, equal to (state==TRACK).

Reset
REQ-023 reset_n=0 SHALL asynchronously force state IDLE and dout=0, dout_valid=0, locked=0, and all counters and the accumulator to 0.
REQ-024 Reset asserted mid-bit SHALL abandon the bit with no dout_valid strobe. After release, operation restarts from IDLE and requires a fresh HUNT.

Structure
REQ-025 The shared package ask_pkg SHALL hold SAMPLE_W=16, the default parameter values and the state enum type.
REQ-026 The magnitude/saturation SHALL be a sub-module ask_abs_sat (16-bit signed in, 15-bit unsigned out, combinational).

Verification (SAMPLES_PER_BIT=16, THRESH_MAG=8192, LOSS_BITS=8)
REQ-027 Scenario: reset_n=0 with din toggling -> dout=0, dout_valid=0, locked=0 throughout.
REQ-028 Scenario: enable=1, din=0 for 200 cycles -> locked stays 0 and no dout_valid.
REQ-029 Scenario: din alternates +20000/-20000 for 16 samples, then 0 for 16 samples -> dout_valid strobes 16 and 32 cycles after HUNT exit, with dout=1 then dout=0.
REQ-030 Scenario: din=-32768 held after lock -> each bit accumulates 16*32767=524272 without overflow and gives dout=1.
REQ-031 Scenario: after lock, 8 bit periods of din=0 -> 8 strobes with dout=0, and locked falls on the edge of the 8th decision.
REQ-032 Scenario: enable dropped at sample index 5 of a bit -> no strobe and locked=0 next cycle. After re-enable, the first bit is re-acquired only from a HUNT threshold crossing.
